if_fetch: RTL and testbench
===========================

IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 Parameter: RESET_VECTOR, default 30'h0, word address fetched first after reset.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 stall  in  1  pipeline stall; high = hold IF register and PC.
REQ-005 flush  in  1  pipeline flush/redirect; high = load new_pc.
REQ-006 new_pc  in  30  redirect word address, used with flush.
REQ-007 br_taken  in  1  branch taken, resolved in ID.
REQ-008 br_addr  in  30  branch target word address.
REQ-009 bus_req  out  1  instruction bus request.
REQ-010 bus_addr  out  30  instruction word address (= pc).
REQ-011 bus_rdy_  in  1  active-low bus ready; data valid on bus_rd_data when low.
REQ-012 bus_rd_data  in  32  fetched instruction word.
REQ-013 if_pc  out  30  registered PC of the instruction in IF/ID.
REQ-014 if_insn  out  32  registered instruction.
REQ-015 if_en  out  1  registered valid for if_pc/if_insn.
REQ-016 busy  out  1  high while bus_req=1 and bus_rdy_=1, i.e. waiting on the bus.

Function
REQ-017 States: S_REQ (bus_req=1, bus_addr=pc) and S_HOLD (bus_req=0, buffered word pending); bus_req and bus_addr are combinational from state and pc.
REQ-018 Per-edge priority: flush > stall > br_taken > bus completion > wait.
REQ-019 flush=1: pc<=new_pc; if_pc<=0, if_insn<=32'h0 (NOP), if_en<=0; buffer discarded; state<=S_REQ; applies even when stall=1; any bus data that cycle is discarded.
REQ-020 stall=1, flush=0: if_pc/if_insn/if_en and pc hold; in S_REQ with bus_rdy_=0, bus_rd_data is captured into the skid buffer and state<=S_HOLD.
REQ-021 br_taken=1, stall=0, flush=0: pc<=br_addr; IF register loaded with bubble (if_en<=0, if_insn<=NOP, if_pc<=0); bus data that cycle is discarded; state<=S_REQ.
REQ-022 S_REQ, bus_rdy_=0, no higher-priority event: if_pc<=pc, if_insn<=bus_rd_data, if_en<=1, pc<=pc+1; one instruction per cycle at zero wait states.
REQ-023 S_REQ, bus_rdy_=1, stall=0: bubble loaded (if_en<=0, if_insn<=NOP); pc holds; bus_req remains 1 at the same address.
REQ-024 S_HOLD, stall=0, no flush or branch: IF register loaded from buffer with the held pc, pc<=pc+1, state<=S_REQ.
REQ-025 PC increment is 30-bit modulo; 30'h3FFF_FFFF+1 wraps to 0.
REQ-026 An abandoned bus request (flush or branch while bus_rdy_=1) is legal; the bus slave tolerates an address change without completion.

Reset
REQ-027 While rst=0: pc=RESET_VECTOR, state=S_REQ, if_pc=0, if_insn=32'h0, if_en=0, buffer=0, bus_req=0.
REQ-028 Reset asserted mid-transaction aborts it immediately; the first request after release is at RESET_VECTOR.

Configuration
REQ-029 Macro IF_SKID_BUF_EN defined: skid buffer and S_HOLD implemented per REQ-020/REQ-024.
REQ-030 Macro undefined: no buffer and no S_HOLD; while stall=1, bus_req=0 and any returned word is dropped; after stall releases, the same pc is re-fetched.

Verification
REQ-031 Reset release with RESET_VECTOR=30'h100, bus_rdy_=0 every cycle -> bus_addr sequence 100,101,102; if_pc follows one cycle later with if_en=1.
REQ-032 bus_rdy_=1 for 3 cycles at pc=30'h10 -> busy=1 and if_en=0 for 3 cycles, then if_pc=10 with the correct word.
REQ-033 stall=1 for 2 cycles coincident with a ready word 32'hDEAD_BEEF at pc=30'h20 -> IF register holds; on release if_insn=DEADBEEF, if_pc=20; without IF_SKID_BUF_EN, pc 20 is re-requested instead.
REQ-034 br_taken=1, br_addr=30'h40, while ready at pc=30'h21 -> next if_en=0, next bus_addr=40.
REQ-035 flush=1 with stall=1, new_pc=30'h8 -> if_en=0, next bus_addr=8, and the pending buffer is dropped.
REQ-036 pc=30'h3FFF_FFFF completes -> next bus_addr=0.

Source files
------------

// File: rtl/if_fetch.sv
// ============================================================================
// if_fetch -- instruction fetch stage with optional one-entry skid buffer
//
// Issues one instruction-bus request per cycle at the current PC and loads
// the returned word into the IF/ID register.  Redirects (flush, taken branch)
// replace the PC and insert a bubble.  A stall freezes the PC and the IF/ID
// register.
//
// Configuration macro:
//   IF_SKID_BUF_EN  defined   : a word that returns while stalled is kept in
//                               a skid buffer (state S_HOLD) and delivered
//                               on stall release without a re-fetch.
//                   undefined : no buffer; bus_req drops while stalled and
//                               the same PC is fetched again afterwards.
//
// Parameters:
//   RESET_VECTOR  word address of the first fetch after reset
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst          asynchronous active-low reset
//   stall        hold PC and IF/ID register
//   flush        redirect to new_pc (highest priority, overrides stall)
//   new_pc       redirect word address
//   br_taken     taken branch resolved in ID
//   br_addr      branch target word address
//   bus_req      instruction bus request (combinational)
//   bus_addr     instruction word address, always equal to the PC
//   bus_rdy_     active-low bus ready, bus_rd_data valid when low
//   bus_rd_data  fetched instruction word
//   if_pc        PC of the instruction held in IF/ID
//   if_insn      instruction held in IF/ID (NOP = 0 for bubbles)
//   if_en        IF/ID contents valid
//   busy         request outstanding and the bus is not ready
// ============================================================================
module if_fetch #(
    parameter logic [29:0] RESET_VECTOR = 30'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [29:0] new_pc,
    input  logic        br_taken,
    input  logic [29:0] br_addr,
    output logic        bus_req,
    output logic [29:0] bus_addr,
    input  logic        bus_rdy_,
    input  logic [31:0] bus_rd_data,
    output logic [29:0] if_pc,
    output logic [31:0] if_insn,
    output logic        if_en,
    output logic        busy
);

    localparam logic [31:0] NOP = 32'h0;

    logic [29:0] pc_reg,      pc_next;
    logic [29:0] if_pc_reg,   if_pc_next;
    logic [31:0] if_insn_reg, if_insn_next;
    logic        if_en_reg,   if_en_next;

`ifdef IF_SKID_BUF_EN
    typedef enum logic {
        S_REQ  = 1'b0,   // requesting at pc
        S_HOLD = 1'b1    // word for pc parked in buf_reg, no request
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] buf_reg,   buf_next;
`endif

    // ------------------------------------------------------------------
    // Bus side outputs.  Reset forces bus_req low even though the state
    // already reads S_REQ, so nothing is requested until release.
    // ------------------------------------------------------------------
`ifdef IF_SKID_BUF_EN
    assign bus_req = rst & (state_reg == S_REQ);
`else
    // Without a buffer a word returned under stall would be lost, so the
    // request is simply withdrawn until the stall clears.
    assign bus_req = rst & ~stall;
`endif
    assign bus_addr = pc_reg;
    assign busy     = bus_req & bus_rdy_;

    assign if_pc   = if_pc_reg;
    assign if_insn = if_insn_reg;
    assign if_en   = if_en_reg;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_reg      <= RESET_VECTOR;
            if_pc_reg   <= '0;
            if_insn_reg <= NOP;
            if_en_reg   <= 1'b0;
`ifdef IF_SKID_BUF_EN
            state_reg   <= S_REQ;
            buf_reg     <= '0;
`endif
        end else begin
            pc_reg      <= pc_next;
            if_pc_reg   <= if_pc_next;
            if_insn_reg <= if_insn_next;
            if_en_reg   <= if_en_next;
`ifdef IF_SKID_BUF_EN
            state_reg   <= state_next;
            buf_reg     <= buf_next;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic, priority: flush > stall > branch > completion.
    // ------------------------------------------------------------------
    always_comb begin
        pc_next      = pc_reg;
        if_pc_next   = if_pc_reg;
        if_insn_next = if_insn_reg;
        if_en_next   = if_en_reg;
`ifdef IF_SKID_BUF_EN
        state_next   = state_reg;
        buf_next     = buf_reg;
`endif

        if (flush) begin
            // Redirect wins even over stall; any returning word is dropped.
            pc_next      = new_pc;
            if_pc_next   = '0;
            if_insn_next = NOP;
            if_en_next   = 1'b0;
`ifdef IF_SKID_BUF_EN
            buf_next     = '0;
            state_next   = S_REQ;
`endif
        end else if (stall) begin
`ifdef IF_SKID_BUF_EN
            // Park a word that completes under stall; pc stays on it so the
            // buffered word and pc remain paired.
            if (state_reg == S_REQ && !bus_rdy_) begin
                buf_next   = bus_rd_data;
                state_next = S_HOLD;
            end
`endif
        end else if (br_taken) begin
            pc_next      = br_addr;
            if_pc_next   = '0;
            if_insn_next = NOP;
            if_en_next   = 1'b0;
`ifdef IF_SKID_BUF_EN
            buf_next     = '0;
            state_next   = S_REQ;
`endif
`ifdef IF_SKID_BUF_EN
        end else if (state_reg == S_HOLD) begin
            if_pc_next   = pc_reg;
            if_insn_next = buf_reg;
            if_en_next   = 1'b1;
            pc_next      = pc_reg + 30'd1;
            state_next   = S_REQ;
`endif
        end else if (!bus_rdy_) begin
            // 30-bit add wraps naturally at the top of the address space.
            if_pc_next   = pc_reg;
            if_insn_next = bus_rd_data;
            if_en_next   = 1'b1;
            pc_next      = pc_reg + 30'd1;
        end else begin
            // Wait state: bubble into IF/ID, keep requesting the same pc.
            if_pc_next   = '0;
            if_insn_next = NOP;
            if_en_next   = 1'b0;
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// ============================================================================
// tb_if_fetch -- self-checking bench for if_fetch
//
// A behavioural model (PC, IF/ID contents, queue of parked words) is advanced
// once per cycle from the same inputs driven to the DUT and compared against
// it.  Directed scenarios pin the model with literal expectations, then a
// randomized run exercises stall/flush/branch/wait-state mixes.
// Works with or without IF_SKID_BUF_EN defined.
// ============================================================================
`timescale 1ns/1ps
module tb_if_fetch;

    localparam logic [29:0] RV = 30'h100;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, flush, br_taken, bus_rdy_;
    logic [29:0] new_pc, br_addr;
    logic [31:0] bus_rd_data;
    logic        bus_req, if_en, busy;
    logic [29:0] bus_addr, if_pc;
    logic [31:0] if_insn;

    if_fetch #(.RESET_VECTOR(RV)) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .flush       (flush),
        .new_pc      (new_pc),
        .br_taken    (br_taken),
        .br_addr     (br_addr),
        .bus_req     (bus_req),
        .bus_addr    (bus_addr),
        .bus_rdy_    (bus_rdy_),
        .bus_rd_data (bus_rd_data),
        .if_pc       (if_pc),
        .if_insn     (if_insn),
        .if_en       (if_en),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Behavioural model
    logic [29:0] m_pc;
    logic [29:0] m_ifpc;
    logic [31:0] m_insn;
    logic        m_en;
    logic [31:0] m_held[$];   // word already returned for m_pc, not yet used
    logic        busy_s;

    function automatic logic [31:0] mem_word(input logic [29:0] a);
        return {a[13:0], a[29:12]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc   = RV;
        m_ifpc = '0;
        m_insn = 32'h0;
        m_en   = 1'b0;
        m_held.delete();
    endtask

    task automatic bubble();
        m_ifpc = '0;
        m_insn = 32'h0;
        m_en   = 1'b0;
    endtask

    // Advance the model by one rising edge using the inputs currently driven.
    task automatic model_step();
        if (flush) begin
            m_pc = new_pc;
            bubble();
            m_held.delete();
        end else if (stall) begin
`ifdef IF_SKID_BUF_EN
            if (m_held.size() == 0 && !bus_rdy_) m_held.push_back(bus_rd_data);
`endif
        end else if (br_taken) begin
            m_pc = br_addr;
            bubble();
            m_held.delete();
        end else if (m_held.size() != 0) begin
            m_ifpc = m_pc;
            m_insn = m_held.pop_front();
            m_en   = 1'b1;
            m_pc   = m_pc + 30'd1;
        end else if (!bus_rdy_) begin
            m_ifpc = m_pc;
            m_insn = bus_rd_data;
            m_en   = 1'b1;
            m_pc   = m_pc + 30'd1;
        end else begin
            bubble();
        end
    endtask

    task automatic check_comb();
        logic exp_req;
`ifdef IF_SKID_BUF_EN
        exp_req = (m_held.size() == 0);
`else
        exp_req = !stall;
`endif
        chk("bus_req",  {63'b0, bus_req}, {63'b0, exp_req});
        chk("busy",     {63'b0, busy},    {63'b0, exp_req & bus_rdy_});
        chk("bus_addr", {34'b0, bus_addr}, {34'b0, m_pc});
    endtask

    task automatic check_regs();
        chk("if_en",   {63'b0, if_en},   {63'b0, m_en});
        chk("if_insn", {32'b0, if_insn}, {32'b0, m_insn});
        if (m_en) chk("if_pc", {34'b0, if_pc}, {34'b0, m_ifpc});
    endtask

    // One cycle: drive at negedge, check combinational outputs, step model,
    // then check registered outputs at the next negedge.
    task automatic drive(input logic st, input logic fl, input logic [29:0] np,
                         input logic br, input logic [29:0] ba, input logic rdy,
                         input logic [31:0] data, input logic use_data);
        stall    = st;
        flush    = fl;
        new_pc   = np;
        br_taken = br;
        br_addr  = ba;
        bus_rdy_ = rdy;
        if (use_data)  bus_rd_data = data;
        else if (rdy)  bus_rd_data = $urandom;
        else           bus_rd_data = mem_word(bus_addr);
        #1;
        busy_s = busy;
        check_comb();
        model_step();
        @(negedge clk);
        check_regs();
    endtask

    task automatic fetch(input logic rdy);
        drive(1'b0, 1'b0, '0, 1'b0, '0, rdy, '0, 1'b0);
    endtask

    task automatic redirect(input logic [29:0] np);
        drive(1'b0, 1'b1, np, 1'b0, '0, 1'b1, '0, 1'b0);
    endtask

    initial begin
        rst = 1'b0; stall = 1'b0; flush = 1'b0; br_taken = 1'b0;
        bus_rdy_ = 1'b1; new_pc = '0; br_addr = '0; bus_rd_data = '0;
        model_reset();
        @(negedge clk); @(negedge clk);

        // Reset state
        chk("rst_bus_req", {63'b0, bus_req}, 64'd0);
        chk("rst_if_en",   {63'b0, if_en},   64'd0);
        chk("rst_if_insn", {32'b0, if_insn}, 64'd0);
        chk("rst_if_pc",   {34'b0, if_pc},   64'd0);
        chk("rst_addr",    {34'b0, bus_addr}, 64'h100);
        rst = 1'b1;

        // Zero-wait streaming from the reset vector
        fetch(1'b0);
        chk("rv_if_pc0", {34'b0, if_pc}, 64'h100);
        chk("rv_en0",    {63'b0, if_en}, 64'd1);
        chk("rv_addr1",  {34'b0, bus_addr}, 64'h101);
        fetch(1'b0);
        chk("rv_if_pc1", {34'b0, if_pc}, 64'h101);
        chk("rv_addr2",  {34'b0, bus_addr}, 64'h102);
        fetch(1'b0);
        chk("rv_if_pc2", {34'b0, if_pc}, 64'h102);

        // Three wait states at pc 0x10
        redirect(30'h10);
        for (int i = 0; i < 3; i++) begin
            fetch(1'b1);
            chk("wait_busy", {63'b0, busy_s}, 64'd1);
            chk("wait_en",   {63'b0, if_en},  64'd0);
        end
        fetch(1'b0);
        chk("wait_if_pc",   {34'b0, if_pc},   64'h10);
        chk("wait_if_insn", {32'b0, if_insn}, {32'b0, mem_word(30'h10)});

        // Stall coincident with a returning word at pc 0x20
        redirect(30'h20);
        drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, 32'hDEAD_BEEF, 1'b1);
        chk("stall_hold_en", {63'b0, if_en}, 64'd0);
        drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b1, '0, 1'b0);
        chk("stall_hold_en2", {63'b0, if_en}, 64'd0);
        fetch(1'b1);
`ifdef IF_SKID_BUF_EN
        chk("skid_insn", {32'b0, if_insn}, 64'hDEAD_BEEF);
        chk("skid_pc",   {34'b0, if_pc},   64'h20);
        chk("skid_addr", {34'b0, bus_addr}, 64'h21);
`else
        chk("refetch_addr", {34'b0, bus_addr}, 64'h20);
        fetch(1'b0);
        chk("refetch_pc", {34'b0, if_pc}, 64'h20);
`endif

        // Taken branch while ready at pc 0x21
        redirect(30'h21);
        drive(1'b0, 1'b0, '0, 1'b1, 30'h40, 1'b0, '0, 1'b0);
        chk("br_en",   {63'b0, if_en},    64'd0);
        chk("br_addr", {34'b0, bus_addr}, 64'h40);

        // Flush during stall drops any parked word
        redirect(30'h30);
        drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
        drive(1'b1, 1'b1, 30'h8, 1'b0, '0, 1'b0, '0, 1'b0);
        chk("fl_en",   {63'b0, if_en},    64'd0);
        chk("fl_addr", {34'b0, bus_addr}, 64'h8);
        fetch(1'b1);
        chk("fl_dropped", {63'b0, if_en}, 64'd0);
        fetch(1'b0);
        chk("fl_if_pc", {34'b0, if_pc}, 64'h8);

        // PC wrap
        redirect(30'h3FFF_FFFF);
        fetch(1'b0);
        chk("wrap_if_pc", {34'b0, if_pc},    64'h3FFF_FFFF);
        chk("wrap_addr",  {34'b0, bus_addr}, 64'h0);

        // Randomized mix
        for (int i = 0; i < 3000; i++) begin
            logic        st, fl, br, rdy;
            logic [29:0] np, ba;
            st  = ($urandom_range(0, 99) < 20);
            fl  = ($urandom_range(0, 99) < 5);
            br  = ($urandom_range(0, 99) < 10);
            rdy = ($urandom_range(0, 99) < 35);
            np  = ($urandom_range(0, 3) == 0) ? 30'h3FFF_FFFE + 30'($urandom_range(0, 1))
                                              : 30'($urandom);
            ba  = 30'($urandom);
            drive(st, fl, np, br, ba, rdy, '0, 1'b0);
        end

        // Asynchronous reset in the middle of a wait state
        redirect(30'h55);
        stall = 1'b0; flush = 1'b0; br_taken = 1'b0; bus_rdy_ = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("arst_bus_req", {63'b0, bus_req}, 64'd0);
        chk("arst_en",      {63'b0, if_en},   64'd0);
        chk("arst_addr",    {34'b0, bus_addr}, 64'h100);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        fetch(1'b0);
        chk("arst_first_pc", {34'b0, if_pc}, 64'h100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time limit so the run always terminates.
    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
